svm_fea_dot: RTL and testbench
==============================

Name: svm_fea_dot

Overview:
- Receive end of the normalized HOG feature stream (`fea` / `i_valid`) produced by the block normalizer.
- Groups features into 36-entry blocks (4 cells x 9 bins) and computes the signed dot product of each block with a programmable 36-entry SVM weight table.
- Emits one partial score per block, with a block index, to the window-level detection accumulator downstream.

Parameters:
- FEA_I, 4, integer bits of feature (unsigned).
- FEA_F, 8, fractional bits of feature.
- W_I, 4, integer bits of weight (two's complement, sign included).
- W_F, 8, fractional bits of weight.
- BLK_LEN, 36, features per block.
- NUM_BLK, 1131, blocks per frame (39 x 29); block index wraps after NUM_BLK-1.
- ACC_W, 32, accumulator/output width (signed, fraction FEA_F+W_F).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- fea  in  FEA_I+FEA_F  normalized feature, unsigned Q4.8
- i_valid  in  1  fea qualifier; one feature per high cycle
- w_we  in  1  weight write enable
- w_addr  in  6  weight index 0..BLK_LEN-1
- w_data  in  W_I+W_F  signed weight Q4.8
- o_sum  out  ACC_W  signed block dot product, Q(ACC_W-16).16
- o_pos  out  1  o_sum > 0
- o_blk  out  11  block index of o_sum
- o_valid  out  1  one-cycle pulse qualifying o_sum/o_pos/o_blk

Behaviour:
- Reset (rst==0 at posedge):
  - o_valid=0, o_sum=0, o_pos=0, o_blk=0.
  - Feature index=0, block counter=0, all pipeline valid bits cleared.
  - Weight RAM contents are not cleared.
- Reset mid-block discards the partial sum. No o_valid is produced for the aborted block. The next accepted feature is index 0 of block 0.
- Feature index counts only i_valid cycles. Gaps of any length between features are legal and do not reset the index. After index BLK_LEN-1 the index returns to 0.
- Pipeline (all registered):
  - S1: fea, index and last flag (index==BLK_LEN-1) registered; weight RAM read at index (synchronous read).
  - S2: signed product of zero-extended fea x weight, 25 bits, Q8.16.
  - S3: accumulator. If the product carries index 0, acc <= sign-extended product (fresh start). Otherwise acc <= acc + product.
- Output:
  - When S3 processes the last flag, the following cycle shows o_valid=1, o_sum=final acc, o_pos=(acc>0), o_blk=block counter.
  - The block counter then increments, wrapping NUM_BLK-1 -> 0.
  - Latency: o_valid rises exactly 3 cycles after the cycle in which the 36th i_valid was sampled.
  - o_sum/o_pos/o_blk hold their values until the next o_valid.
- Back-to-back blocks: index 0 of the next block may arrive the cycle after the last feature. No bubble and no loss; the fresh-start rule guarantees isolation between blocks.
- Width:
  - |sum| <= 36 x 4095 x 2048 < 2^29, so no overflow in ACC_W=32 and no saturation logic.
  - Results are bit-exact integer arithmetic; no rounding.
- Weight RAM:
  - Single write port, BLK_LEN x 12 bits.
  - w_we with w_addr >= BLK_LEN is ignored.
  - Writes are allowed any time. A same-cycle read of the address being written returns the old value (read-first). The new value is used from the next read onward.
- i_valid with X on fea is not checked; behaviour is defined only for known inputs.

Test Plan:
- Identity block: all weights 0x100, 36 features 0x100 contiguous -> o_valid 3 cycles after 36th input, o_sum=0x00240000, o_pos=1, o_blk=0.
- Alternating sign:
  - Stimulus: weight[k]=0x100 (k even) / 0xF00 (k odd); fea_k=k x 0x010.
  - Response: o_sum=0xFFFEE000 (-73728), o_pos=0.
- Gapped input: identity block with i_valid low for 1-5 random cycles between features -> same o_sum=0x00240000, single o_valid pulse, 3 cycles after last feature.
- Back-to-back and wrap:
  - Stimulus: NUM_BLK=3, four contiguous identity blocks (144 cycles).
  - Response: four o_valid pulses 36 cycles apart, o_blk=0,1,2,0, each o_sum=0x00240000.
- Reset mid-block:
  - Stimulus: 20 features, rst low 1 cycle, then a full identity block.
  - Response: no o_valid for the partial block; one o_valid with o_sum=0x00240000, o_blk=0.
- Weight read-during-write:
  - Stimulus: all weights 0x100; write weight[0]=0x200 in the same cycle as feature 0 (0x100) is sampled; remaining features 0x100.
  - Response: o_sum=0x00240000 (old weight used).
  - A second identity block then gives o_sum=0x00250000.

Source files
------------

// File: rtl/svm_fea_dot.sv
// svm_fea_dot: dot product of each 36-feature HOG block with a programmable SVM weight table
module svm_fea_dot #(
   parameter int FEA_I   = 4,
   parameter int FEA_F   = 8,
   parameter int W_I     = 4,
   parameter int W_F     = 8,
   parameter int BLK_LEN = 36,
   parameter int NUM_BLK = 1131,
   parameter int ACC_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FEA_I+FEA_F-1:0] fea,
   input  logic                   i_valid,
   input  logic                   w_we,
   input  logic [5:0]             w_addr,
   input  logic [W_I+W_F-1:0]     w_data,
   output logic [ACC_W-1:0]       o_sum,
   output logic                   o_pos,
   output logic [10:0]            o_blk,
   output logic                   o_valid
);

   localparam int FW = FEA_I + FEA_F;
   localparam int WW = W_I + W_F;
   localparam int PW = FW + WW + 1;
   localparam logic [5:0]  LAST_IDX = 6'(BLK_LEN - 1);
   localparam logic [10:0] LAST_BLK = 11'(NUM_BLK - 1);

   logic [5:0]              idx;
   logic [WW-1:0]           wram [BLK_LEN];
   logic [FW-1:0]           s1_fea;
   logic [WW-1:0]           s1_w;
   logic                    s1_v;
   logic                    s1_first;
   logic                    s1_last;
   logic signed [PW-1:0]    s2_prod;
   logic                    s2_v;
   logic                    s2_first;
   logic                    s2_last;
   logic signed [ACC_W-1:0] prod_x;
   logic signed [ACC_W-1:0] acc;
   logic                    s3_v;
   logic                    s3_last;
   logic [10:0]             blk;

   // Weight table: out-of-range writes dropped; read-first so a same-cycle write is seen next read
   always_ff @(posedge clk) begin
      if (w_we && w_addr <= LAST_IDX) wram[w_addr] <= w_data;
      s1_w <= wram[idx];
   end

   // S1: feature index counts accepted features only, tagging block start and end
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx      <= '0;
         s1_v     <= 1'b0;
         s1_fea   <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         s1_v <= i_valid;
         if (i_valid) begin
            s1_fea   <= fea;
            s1_first <= idx == '0;
            s1_last  <= idx == LAST_IDX;
            idx      <= (idx == LAST_IDX) ? '0 : idx + 6'd1;
         end
      end
   end

   // S2: unsigned feature times signed weight, exact 25-bit product
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_v     <= 1'b0;
         s2_prod  <= '0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
      end else begin
         s2_v     <= s1_v;
         s2_prod  <= PW'($signed({1'b0, s1_fea})) * PW'($signed(s1_w));
         s2_first <= s1_first;
         s2_last  <= s1_last;
      end
   end

   // Sign extension of the product into the accumulator width
   always_comb prod_x = ACC_W'(s2_prod);

   // S3: the first feature of a block restarts the sum, isolating back-to-back blocks
   always_ff @(posedge clk) begin
      if (!rst) begin
         s3_v    <= 1'b0;
         s3_last <= 1'b0;
         acc     <= '0;
      end else begin
         s3_v    <= s2_v;
         s3_last <= s2_last;
         if (s2_v) acc <= s2_first ? prod_x : acc + prod_x;
      end
   end

   // Output: publish the finished block and advance the wrapping block counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_pos   <= 1'b0;
         o_blk   <= '0;
         blk     <= '0;
      end else begin
         o_valid <= s3_v && s3_last;
         if (s3_v && s3_last) begin
            o_sum <= acc;
            o_pos <= acc > 0;
            o_blk <= blk;
            blk   <= (blk == LAST_BLK) ? '0 : blk + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_svm_fea_dot.sv
// tb_svm_fea_dot: table vectors, corner sequences and random blocks against an arithmetic model
module tb_svm_fea_dot;

   localparam int NB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] fea = '0;
   logic        i_valid = 1'b0;
   logic        w_we = 1'b0;
   logic [5:0]  w_addr = '0;
   logic [11:0] w_data = '0;
   logic [31:0] o_sum;
   logic        o_pos;
   logic [10:0] o_blk;
   logic        o_valid;

   svm_fea_dot #(.NUM_BLK(NB)) dut (
      .clk(clk), .rst(rst), .fea(fea), .i_valid(i_valid), .w_we(w_we),
      .w_addr(w_addr), .w_data(w_data), .o_sum(o_sum), .o_pos(o_pos),
      .o_blk(o_blk), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stamp;
      logic [31:0] sum;
      logic        pos;
      logic [10:0] blk;
   } ev_t;

   typedef struct {
      string       nm;
      logic [11:0] w_even;
      logic [11:0] w_odd;
      logic [11:0] f_base;
      logic [11:0] f_step;
      int          gmin;
      int          gmax;
      logic [31:0] exp_sum;
      logic        exp_pos;
   } vec_t;

   int                cyc = 0;
   int                n_chk = 0;
   int                n_fail = 0;
   int                eblk = 0;
   logic [31:0]       last_sum;
   logic signed [11:0] mw [36];
   logic [11:0]       bf [36];
   ev_t               got_q[$];
   ev_t               exp_q[$];
   vec_t              tbl[3];

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every output pulse with the cycle it appeared in
   always @(negedge clk) if (o_valid) got_q.push_back('{cyc, o_sum, o_pos, o_blk});

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
      w_we    = 1'b0;
   endtask

   task automatic wr(input int a, input logic [11:0] d);
      @(negedge clk);
      i_valid = 1'b0;
      w_we    = 1'b1;
      w_addr  = 6'(a);
      w_data  = d;
      if (a < 36) mw[a] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      i_valid = 1'b0;
      w_we    = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      eblk = 0;
   endtask

   // Feed the first n features of bf; a complete block queues its expected result
   task automatic run_blk(input int n, input int gmin, input int gmax, input bit wtest);
      longint s = 0;
      for (int k = 0; k < n; k++) begin
         int g = gmin + int'($urandom % 32'(gmax - gmin + 1));
         repeat (g) idle();
         @(negedge clk);
         fea     = bf[k];
         i_valid = 1'b1;
         w_we    = 1'b0;
         if (wtest && k == 0) begin
            w_we   = 1'b1;
            w_addr = 6'd0;
            w_data = 12'h200;
         end
         s += longint'(bf[k]) * longint'(mw[k]);
         if (wtest && k == 0) mw[0] = 12'h200;
      end
      if (n == 36) begin
         exp_q.push_back('{cyc + 4, s[31:0], $signed(s[31:0]) > 0, 11'(eblk)});
         last_sum = s[31:0];
         eblk = (eblk + 1) % NB;
      end
   endtask

   task automatic settle(input string nm);
      int n;
      repeat (8) idle();
      chk({nm, " pulse count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({nm, " cycle"}, got_q[i].stamp, exp_q[i].stamp);
         chk({nm, " o_sum"}, got_q[i].sum, exp_q[i].sum);
         chk({nm, " o_pos"}, got_q[i].pos, exp_q[i].pos);
         chk({nm, " o_blk"}, got_q[i].blk, exp_q[i].blk);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic fill_ident();
      for (int k = 0; k < 36; k++) bf[k] = 12'h100;
   endtask

   initial begin
      tbl[0] = '{"identity", 12'h100, 12'h100, 12'h100, 12'h000, 0, 0, 32'h00240000, 1'b1};
      tbl[1] = '{"alternating", 12'h100, 12'hF00, 12'h000, 12'h010, 0, 0, 32'hFFFEE000, 1'b0};
      tbl[2] = '{"gapped", 12'h100, 12'h100, 12'h100, 12'h000, 1, 5, 32'h00240000, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset o_valid", o_valid, 0);
      chk("reset o_sum", o_sum, 0);
      chk("reset o_pos", o_pos, 0);
      chk("reset o_blk", o_blk, 0);
      rst = 1'b1;

      foreach (tbl[t]) begin
         for (int k = 0; k < 36; k++) begin
            wr(k, (k % 2 == 0) ? tbl[t].w_even : tbl[t].w_odd);
            bf[k] = tbl[t].f_base + 12'(k) * tbl[t].f_step;
         end
         run_blk(36, tbl[t].gmin, tbl[t].gmax, 1'b0);
         settle(tbl[t].nm);
         chk({tbl[t].nm, " sum const"}, o_sum, tbl[t].exp_sum);
         chk({tbl[t].nm, " pos const"}, o_pos, tbl[t].exp_pos);
      end

      do_reset();
      for (int k = 0; k < 36; k++) wr(k, 12'h100);
      fill_ident();
      repeat (4) run_blk(36, 0, 0, 1'b0);
      settle("wrap");

      run_blk(20, 0, 0, 1'b0);
      do_reset();
      run_blk(36, 0, 0, 1'b0);
      settle("reset mid-block");
      chk("reset mid-block blk const", o_blk, 0);

      run_blk(36, 0, 0, 1'b1);
      settle("rdw old");
      chk("rdw old const", o_sum, 32'h00240000);
      run_blk(36, 0, 0, 1'b0);
      settle("rdw new");
      chk("rdw new const", o_sum, 32'h00250000);

      wr(36, 12'h7FF);
      wr(63, 12'h7FF);
      run_blk(36, 0, 0, 1'b0);
      settle("oob write");

      for (int k = 0; k < 36; k++) wr(k, 12'($urandom));
      repeat (3) begin
         for (int k = 0; k < 36; k++) bf[k] = 12'($urandom);
         run_blk(36, 0, 2, 1'b0);
      end
      settle("random");

      for (int k = 0; k < 36; k++) begin
         wr(k, 12'h800);
         bf[k] = 12'hFFF;
      end
      run_blk(36, 0, 0, 1'b0);
      settle("most negative");

      repeat (10) idle();
      chk("hold o_sum", o_sum, last_sum);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
